// File: rtl/ctrl_seq_unit.sv
// Multi-cycle control sequencer: T0 fetch, T1..T3 execute, one-hot register enables.
// Optional CTRL_SEQ_STALL_EN adds a stall input that freezes the step and blanks all outputs.
module ctrl_seq_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned PC_IDX = 7
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
`ifdef CTRL_SEQ_STALL_EN
  input  logic              stall,
`endif
  input  logic [DATA_W-1:0] din,
  output logic [NREG-1:0]   rin,
  output logic [NREG-1:0]   rout,
  output logic              ain,
  output logic              gin,
  output logic              gout,
  output logic              din_out,
  output logic              pcin,
  output logic              pcout,
  output logic              addsub,
  output logic              xorctrl,
  output logic              done,
  output logic              busy,
  output logic              illegal
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [DATA_W-1:0] ir;
  logic [2:0]        op, rx, ry;
  logic              bad;
  logic              adv;
  logic              unused_ir_bits;

  assign op = ir[15:13];
  assign rx = ir[12:10];
  assign ry = ir[9:7];
  assign unused_ir_bits = ^ir;

  // ry is only an operand for mv and the ALU ops; mvi carries its data on din
  assign bad = (op > OP_XOR) || (32'(rx) >= NREG) || ((op != OP_MVI) && (32'(ry) >= NREG));

`ifdef CTRL_SEQ_STALL_EN
  assign adv = ~stall;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
    end else if (adv) begin
      state <= state_nx;
      if (state == T0 && run) ir <= din;
    end
  end

  always_comb begin
    state_nx = state;
    rin      = '0;
    rout     = '0;
    ain      = 1'b0;
    gin      = 1'b0;
    gout     = 1'b0;
    din_out  = 1'b0;
    addsub   = 1'b0;
    xorctrl  = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state != T0);
    unique case (state)
      T0: if (run) state_nx = T1;
      T1: begin
        if (bad) begin
          done     = 1'b1;
          illegal  = 1'b1;
          state_nx = T0;
        end else if (op == OP_MV) begin
          rout     = ONE << ry;
          rin      = ONE << rx;
          done     = 1'b1;
          state_nx = T0;
        end else if (op == OP_MVI) begin
          din_out  = 1'b1;
          rin      = ONE << rx;
          done     = 1'b1;
          state_nx = T0;
        end else begin
          rout     = ONE << rx;
          ain      = 1'b1;
          state_nx = T2;
        end
      end
      T2: begin
        rout     = ONE << ry;
        gin      = 1'b1;
        addsub   = (op == OP_SUB);
        xorctrl  = (op == OP_XOR);
        state_nx = T3;
      end
      T3: begin
        gout     = 1'b1;
        rin      = ONE << rx;
        done     = 1'b1;
        state_nx = T0;
      end
      default: state_nx = T0;
    endcase
`ifdef CTRL_SEQ_STALL_EN
    // stalled step re-presents its outputs once stall drops, so blank them here
    if (stall) begin
      rin     = '0;
      rout    = '0;
      ain     = 1'b0;
      gin     = 1'b0;
      gout    = 1'b0;
      din_out = 1'b0;
      addsub  = 1'b0;
      xorctrl = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
      busy    = 1'b0;
    end
`endif
  end

  assign pcin  = rin[PC_IDX];
  assign pcout = rout[PC_IDX];

  // ADD is decoded through the default ALU path
  logic unused_op_add;
  assign unused_op_add = ^OP_ADD;

endmodule
